var_delay_line: RTL
===================

Name: var_delay_line

Overview:
- Multi-channel, valid-tagged delay line with a run-time selectable delay, stall (hold) and flush.
- Delay is chosen from 1..MAX_DELAY.
- Aligns LSTM gate/state operands whose producer latencies differ by configuration, replacing fixed-depth register chains where the latency is not known at elaboration.
- Sits between the MAC/activation pipeline stages and the cell-state update datapath.

Parameters:
- WIDTH, 16, bits per channel
- NUM_CH, 4, number of parallel channels sharing one delay and one valid
- MAX_DELAY, 8, number of physical stages; maximum delay in cycles (>=1)
- DEFAULT_DELAY, 4, delay in effect after reset (1..MAX_DELAY)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_data  input  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- stall  input  1  1 = freeze all stages, counters and outputs
- flush  input  1  1 = invalidate all in-flight entries
- load_delay  input  1  1 = adopt delay_sel this edge
- delay_sel  input  $clog2(MAX_DELAY+1)  requested delay in cycles
- cur_delay  output  $clog2(MAX_DELAY+1)  delay currently in effect
- out_valid  output  1  output word valid
- out_data  output  NUM_CH*WIDTH  delayed data
- busy  output  1  any valid entry in stages 0..cur_delay-1

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Storage: MAX_DELAY stages s[0..MAX_DELAY-1], each holding {v, data}.
- Shift edge (stall=0): s[0] <= {in_valid, in_data}; s[i] <= s[i-1].
- Stall edge: every stage holds; nothing is lost.
- Output is a combinational mux from registers: out_data = s[cur_delay-1].data; out_valid = s[cur_delay-1].v && (settle_cnt==0).
- Latency: a word presented at unstalled edge k appears at the outputs after edge k+D-1, i.e. exactly D unstalled edges later counting edge k. Stalled edges add one cycle each.
- delay_sel is clamped: 0 -> 1, >MAX_DELAY -> MAX_DELAY. Clamping applies both to load and to the cur_delay value.
- Load (load_delay=1 at edge):
  - cur_delay <= clamped delay_sel (D).
  - settle_cnt <= D-1 if the edge shifts, D if stalled.
- settle_cnt decrements by 1 on each unstalled edge while nonzero.
- While settle_cnt != 0, out_valid = 0. This blanks words that experienced a mixed delay. Data is still shifted, not cleared.
- Flush: all s[i].v <= 0 and settle_cnt <= 0. Data bits are retained; in_valid at a flush edge is discarded.
- Flush overrides stall for valid bits: valids are cleared and no shift occurs.
- Simultaneous load+flush: cur_delay loaded, settle_cnt <= 0 (pipeline empty, nothing to blank).
- Simultaneous load+stall: cur_delay loaded, settle_cnt <= D, no shift.
- Priority: reset > flush > load_delay > stall/shift.
- Reset:
  - all s[i].v = 0 and s[i].data = 0
  - cur_delay = DEFAULT_DELAY, settle_cnt = 0
  - hence out_valid = 0, out_data = 0, busy = 0
  - reset mid-operation discards all in-flight words.
- Stages at index >= cur_delay still shift but never drive outputs or busy.
- Word count is not tracked; no back-pressure beyond stall.

Test Plan:
- Reset, then in_valid=1, in_data=0x0001_0002_0003_0004 at edge 0, zeros after -> out_valid=1 with that data only after edge 3 (DEFAULT_DELAY=4); busy=1 after edges 0..3 and 0 after edge 4.
- Streaming counter data; load_delay=1, delay_sel=2 at edge 10 -> cur_delay=2 after edge 10; out_valid=0 after edge 10; after edge 11 out_valid=1 showing the word captured at edge 10.
- delay_sel=0 load -> cur_delay=1, output equals previous-edge input. delay_sel=15 load -> cur_delay=8.
- With D=3, word A in; stall=1 for 5 cycles after edge 0 -> A appears 5 cycles later than nominal, out_data constant during stall, no words dropped or duplicated.
- Three valid words in flight; flush=1 with in_valid=1 -> out_valid=0 and busy=0 after the flush edge; the next valid word appears after its full D edges.
- Reset asserted mid-stream with load and stall active -> all outputs 0 and cur_delay=4 after the reset edge.

Source files
------------

// File: rtl/var_delay_line.sv
// Multi-channel, valid-tagged delay line with a run-time selectable delay of
// 1..MAX_DELAY cycles, stall (hold), flush and post-reconfiguration blanking.
module var_delay_line #(
  parameter int WIDTH         = 16,
  parameter int NUM_CH        = 4,
  parameter int MAX_DELAY     = 8,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [NUM_CH*WIDTH-1:0]        in_data,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           load_delay,
  input  logic [$clog2(MAX_DELAY+1)-1:0] delay_sel,
  output logic [$clog2(MAX_DELAY+1)-1:0] cur_delay,
  output logic                           out_valid,
  output logic [NUM_CH*WIDTH-1:0]        out_data,
  output logic                           busy
);

  localparam int DW     = $clog2(MAX_DELAY + 1);
  localparam int DATA_W = NUM_CH * WIDTH;

  logic [MAX_DELAY-1:0] stage_v;
  logic [DATA_W-1:0]    stage_data [MAX_DELAY];
  logic [DW-1:0]        settle_cnt;
  logic [DW-1:0]        delay_clamped;
  logic                 tap_valid;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] sel);
    if (sel == '0)                   return DW'(1);
    else if (sel > DW'(MAX_DELAY))   return DW'(MAX_DELAY);
    else                             return sel;
  endfunction

  assign delay_clamped = clamp_delay(delay_sel);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_v    <= '0;
      // NOTE: the data array is reset too, so out_data reads zero after reset
      // rather than stale contents; in-flight words are discarded.
      for (int i = 0; i < MAX_DELAY; i++) stage_data[i] <= '0;
      cur_delay  <= DW'(DEFAULT_DELAY);
      settle_cnt <= '0;
    end else if (flush) begin
      // Valids dropped, data retained, no shift; nothing left to blank.
      stage_v    <= '0;
      settle_cnt <= '0;
      if (load_delay) cur_delay <= delay_clamped;
    end else begin
      if (load_delay) begin
        cur_delay  <= delay_clamped;
        settle_cnt <= stall ? delay_clamped : delay_clamped - DW'(1);
      end else if (!stall && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - DW'(1);
      end

      if (!stall) begin
        stage_v[0]    <= in_valid;
        stage_data[0] <= in_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
          stage_v[i]    <= stage_v[i-1];
          stage_data[i] <= stage_data[i-1];
        end
      end
    end
  end

  // Output tap at stage cur_delay-1; busy covers only the active stages.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_data  = stage_data[0];
    tap_valid = stage_v[0];
    busy      = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (DW'(i + 1) == cur_delay) begin
        out_data  = stage_data[i];
        tap_valid = stage_v[i];
      end
      if (DW'(i) < cur_delay) busy = busy | stage_v[i];
    end
  end

  // Words that straddled a delay change are blanked until the pipe settles.
  assign out_valid = tap_valid && (settle_cnt == '0);

endmodule
